// File: rtl/reg_bank_pkg.sv
// Shared control definitions for the bus registers: legacy single-register ops,
// banked-register ops and the bank swap sequencer states.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    REG_NOP    = 2'd0,
    REG_LOAD   = 2'd1,
    REG_ENABLE = 2'd2
  } reg_op_e;

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    LOAD   = 3'd1,
    ENABLE = 3'd2,
    INC    = 3'd3,
    DEC    = 3'd4,
    SWAP   = 3'd5
  } reg_bank_op_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWAP2 = 1'b1
  } reg_bank_state_e;

endpackage

// File: rtl/reg_bank.sv
// DEPTH x WIDTH register bank on the shared tri-state data bus: load, drive,
// in-place increment/decrement with flags, and a two-cycle swap with register 0.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned SEL_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in,
  output logic [WIDTH-1:0]   out,
  input  logic [SEL_W-1:0]   sel,
  input  reg_bank_op_e       op,
  output logic               zero,
  output logic               carry,
  output logic               busy
);

  localparam logic [SEL_W:0] DEPTH_L = (SEL_W+1)'(DEPTH);

  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [WIDTH-1:0] bank_d [DEPTH];
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  reg_bank_state_e  state_q, state_d;

  logic             sel_ok;
  logic             valid;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] res;

  // Widened compare keeps the range check meaningful when DEPTH is a power of two.
  assign sel_ok = ({1'b0, sel} < DEPTH_L);
  assign valid  = (state_q == IDLE) && sel_ok;
  assign rd     = sel_ok ? bank_q[sel] : '0;

  always_comb begin
    bank_d  = bank_q;
    tmp_d   = tmp_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    state_d = state_q;
    res     = '0;
    if (state_q == SWAP2) begin
      bank_d[0] = tmp_q;
      state_d   = IDLE;
    end else if (valid) begin
      unique case (op)
        LOAD: begin
          bank_d[sel] = in;
          zero_d      = (in == '0);
          carry_d     = 1'b0;
        end
        INC: begin
          res         = rd + WIDTH'(1);
          bank_d[sel] = res;
          carry_d     = (rd == '1);
          zero_d      = (res == '0);
        end
        DEC: begin
          res         = rd - WIDTH'(1);
          bank_d[sel] = res;
          carry_d     = (rd == '0);
          zero_d      = (res == '0);
        end
        SWAP: begin
          // Single write port: park the target in tmp, write register 0 back next edge.
          tmp_d       = rd;
          bank_d[sel] = bank_q[0];
          state_d     = SWAP2;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank_q  <= '{default: '0};
      tmp_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      bank_q  <= bank_d;
      tmp_q   <= tmp_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      state_q <= state_d;
    end
  end

  assign zero  = zero_q;
  assign carry = carry_q;
  assign busy  = (state_q == SWAP2);

  assign out = (!reset && valid && op == ENABLE) ? rd : 'z;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: default 8x4 build plus a 16-bit, 3-deep build.
module tb_reg_bank;
  import reg_bank_pkg::*;

  logic clock;
  logic reset;

  logic [7:0]   in_a;
  wire  [7:0]   out_a;
  logic [1:0]   sel_a;
  reg_bank_op_e op_a;
  logic         zero_a, carry_a, busy_a;

  logic [15:0]  in_b;
  wire  [15:0]  out_b;
  logic [1:0]   sel_b;
  reg_bank_op_e op_b;
  logic         zero_b, carry_b, busy_b;

  logic [7:0]   z8;
  logic [15:0]  z16;

  int unsigned n_vec;
  int unsigned n_bad;

  reg_bank u_a (
    .clock (clock),
    .reset (reset),
    .in    (in_a),
    .out   (out_a),
    .sel   (sel_a),
    .op    (op_a),
    .zero  (zero_a),
    .carry (carry_a),
    .busy  (busy_a)
  );

  reg_bank #(.WIDTH(16), .DEPTH(3)) u_b (
    .clock (clock),
    .reset (reset),
    .in    (in_b),
    .out   (out_b),
    .sel   (sel_b),
    .op    (op_b),
    .zero  (zero_b),
    .carry (carry_b),
    .busy  (busy_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic do_a(input reg_bank_op_e o, input logic [1:0] s, input logic [7:0] d);
    op_a = o; sel_a = s; in_a = d;
    cyc();
    op_a = NOP;
  endtask

  task automatic do_b(input reg_bank_op_e o, input logic [1:0] s, input logic [15:0] d);
    op_b = o; sel_b = s; in_b = d;
    cyc();
    op_b = NOP;
  endtask

  task automatic rd_a(input string tag, input logic [1:0] s, input logic [7:0] exp);
    op_a = ENABLE; sel_a = s;
    #1;
    chk(tag, {24'h0, out_a}, {24'h0, exp});
    op_a = NOP;
    #1;
  endtask

  task automatic rd_b(input string tag, input logic [1:0] s, input logic [15:0] exp);
    op_b = ENABLE; sel_b = s;
    #1;
    chk(tag, {16'h0, out_b}, {16'h0, exp});
    op_b = NOP;
    #1;
  endtask

  task automatic flags_a(input string tag, input logic z, input logic c, input logic b);
    chk(tag, {29'h0, zero_a, carry_a, busy_a}, {29'h0, z, c, b});
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    z8  = 'z;
    z16 = 'z;
    reset = 1'b1;
    op_a = ENABLE; sel_a = 2'd0; in_a = 8'h00;
    op_b = NOP;    sel_b = 2'd0; in_b = 16'h0000;
    #1;
    flags_a("reset_flags", 1'b0, 1'b0, 1'b0);
    chk("reset_out", {24'h0, out_a}, {24'h0, z8});
    op_a = NOP;
    cyc();
    reset = 1'b0;
    #1;

    // load, same-cycle drive, flags
    do_a(LOAD, 2'd3, 8'h00);
    flags_a("load_zero", 1'b1, 1'b0, 1'b0);
    do_a(LOAD, 2'd2, 8'hA5);
    flags_a("load_nz", 1'b0, 1'b0, 1'b0);
    rd_a("rd_r2", 2'd2, 8'hA5);
    rd_a("rd_r1", 2'd1, 8'h00);
    rd_a("rd_r0", 2'd0, 8'h00);

    // increment/decrement wrap and non-wrap
    do_a(LOAD, 2'd1, 8'hFF);
    do_a(INC, 2'd1, 8'h00);
    flags_a("inc_wrap", 1'b1, 1'b1, 1'b0);
    rd_a("inc_wrap_val", 2'd1, 8'h00);
    do_a(DEC, 2'd1, 8'h00);
    flags_a("dec_wrap", 1'b0, 1'b1, 1'b0);
    rd_a("dec_wrap_val", 2'd1, 8'hFF);
    do_a(INC, 2'd2, 8'h00);
    flags_a("inc_plain", 1'b0, 1'b0, 1'b0);
    rd_a("inc_plain_val", 2'd2, 8'hA6);
    do_a(DEC, 2'd2, 8'h00);
    do_a(DEC, 2'd2, 8'h00);
    rd_a("dec_plain_val", 2'd2, 8'hA4);
    do_a(NOP, 2'd2, 8'h00);
    rd_a("nop_val", 2'd2, 8'hA4);

    // swap with an op dropped while busy
    do_a(LOAD, 2'd0, 8'h11);
    do_a(LOAD, 2'd3, 8'h33);
    do_a(SWAP, 2'd3, 8'h00);
    flags_a("swap_busy", 1'b0, 1'b0, 1'b1);
    do_a(LOAD, 2'd1, 8'h77);
    flags_a("swap_done", 1'b0, 1'b0, 1'b0);
    rd_a("swap_r0", 2'd0, 8'h33);
    rd_a("swap_r3", 2'd3, 8'h11);
    rd_a("busy_load_drop", 2'd1, 8'hFF);

    // swap back, driving the bus while busy must stay released
    do_a(SWAP, 2'd3, 8'h00);
    op_a = ENABLE; sel_a = 2'd1;
    #1;
    chk("busy_out_z", {24'h0, out_a}, {24'h0, z8});
    cyc();
    op_a = NOP;
    rd_a("swapb_r0", 2'd0, 8'h11);
    rd_a("swapb_r3", 2'd3, 8'h33);

    // self-swap of register 0 and swap with r2
    do_a(SWAP, 2'd0, 8'h00);
    do_a(NOP, 2'd0, 8'h00);
    rd_a("swap0_r0", 2'd0, 8'h11);
    do_a(SWAP, 2'd2, 8'h00);
    do_a(NOP, 2'd0, 8'h00);
    rd_a("swap2_r0", 2'd0, 8'hA4);
    rd_a("swap2_r2", 2'd2, 8'h11);

    // reset landing in SWAP2
    do_a(LOAD, 2'd1, 8'hFF);
    do_a(INC, 2'd1, 8'h00);
    do_a(SWAP, 2'd3, 8'h00);
    flags_a("pre_rst_flags", 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    op_a = ENABLE; sel_a = 2'd3;
    #1;
    flags_a("mid_rst_flags", 1'b0, 1'b0, 1'b0);
    chk("mid_rst_out", {24'h0, out_a}, {24'h0, z8});
    op_a = NOP;
    cyc();
    reset = 1'b0;
    #1;
    rd_a("rst_r3", 2'd3, 8'h00);
    rd_a("rst_r0", 2'd0, 8'h00);
    rd_a("rst_r2", 2'd2, 8'h00);

    // 16-bit, 3-deep build: wrap and out-of-range select
    do_b(LOAD, 2'd1, 16'hFFFF);
    do_b(INC, 2'd1, 16'h0000);
    chk("b_inc_flags", {30'h0, zero_b, carry_b}, {30'h0, 1'b1, 1'b1});
    rd_b("b_inc_val", 2'd1, 16'h0000);
    do_b(LOAD, 2'd2, 16'hBEEF);
    do_b(LOAD, 2'd3, 16'h1234);
    chk("b_oor_flags", {30'h0, zero_b, carry_b}, {30'h0, 1'b0, 1'b0});
    rd_b("b_oor_out", 2'd3, z16);
    do_b(INC, 2'd3, 16'h0000);
    chk("b_oor_busy", {31'h0, busy_b}, 32'h0);
    do_b(SWAP, 2'd3, 16'h0000);
    chk("b_oor_swap", {31'h0, busy_b}, 32'h0);
    rd_b("b_r2", 2'd2, 16'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
